load_store_unit: RTL



---
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store memory-access stage: alignment check, req/gnt/rvalid memory
// handshake with byte enables and lane-replicated store data, load data
// right-shifted to the addressed lane, and a timeout guard.
module load_store_unit #(
    parameter int unsigned CPU_WORD   = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  is_store,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [CPU_WORD-1:0]   wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [CPU_WORD-1:0]   resp_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [CPU_WORD-1:0]   mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [CPU_WORD-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  is_store_q, is_store_nxt;
    logic [1:0]            off_q, off_nxt;

    logic                  resp_valid_nxt;
    logic                  resp_err_nxt;
    logic [CPU_WORD-1:0]   resp_data_nxt;
    logic                  mem_req_nxt;
    logic                  mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [3:0]            mem_be_nxt;
    logic [CPU_WORD-1:0]   mem_wdata_nxt;

    logic                  err_c;
    logic [3:0]            be_c;
    logic [CPU_WORD-1:0]   wdata_rep_c;
    logic [CPU_WORD-1:0]   load_shift_c;
    logic                  last_c;

    // Accept only from IDLE
    assign req_ready = (state == IDLE);

    // Request decode: alignment/size error, byte enables, lane replication
    always_comb begin
        err_c       = (size == 2'b11)
                    | ((size == 2'b01) & addr[0])
                    | ((size == 2'b10) & (addr[1:0] != 2'b00));
        be_c        = 4'b1111;
        wdata_rep_c = wdata;
        case (size)
            2'b00: begin
                be_c        = 4'b0001 << addr[1:0];
                wdata_rep_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c        = 4'b0011 << addr[1:0];
                wdata_rep_c = {2{wdata[15:0]}};
            end
            default: begin
                be_c        = 4'b1111;
                wdata_rep_c = wdata;
            end
        endcase
        load_shift_c = mem_rdata >> {off_q, 3'b000};
        last_c       = (cnt == CNT_W'(TIMEOUT - 1));
    end

    // Next-state and next-output logic; completion beats timeout in the same cycle
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        is_store_nxt   = is_store_q;
        off_nxt        = off_q;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = resp_err;
        resp_data_nxt  = resp_data;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_be_nxt     = mem_be;
        mem_wdata_nxt  = mem_wdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    is_store_nxt  = is_store;
                    off_nxt       = addr[1:0];
                    resp_data_nxt = '0;
                    if (err_c) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt     = REQ;
                        cnt_nxt       = '0;
                        resp_err_nxt  = 1'b0;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = is_store;
                        mem_addr_nxt  = {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_nxt    = be_c;
                        mem_wdata_nxt = wdata_rep_c;
                    end
                end
            end

            REQ: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (mem_gnt && (is_store_q || mem_rvalid)) begin
                    state_nxt      = RESP;
                    mem_req_nxt    = 1'b0;
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b0;
                    resp_data_nxt  = is_store_q ? '0 : load_shift_c;
                end else if (last_c) begin
                    state_nxt      = RESP;
                    mem_req_nxt    = 1'b0;
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b1;
                    resp_data_nxt  = '0;
                end else if (mem_gnt) begin
                    state_nxt   = WAIT;
                    mem_req_nxt = 1'b0;
                end
            end

            WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (mem_rvalid) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b0;
                    resp_data_nxt  = load_shift_c;
                end else if (last_c) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b1;
                    resp_data_nxt  = '0;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, request context and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            is_store_q <= 1'b0;
            off_q      <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            is_store_q <= is_store_nxt;
            off_q      <= off_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_data  <= resp_data_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_be     <= mem_be_nxt;
            mem_wdata  <= mem_wdata_nxt;
        end
    end

endmodule
